// File: rtl/palette_lut_engine_if.sv
// ---------------------------------------------------------------------------
// palette_lut_engine_if
// Bus bundle for palette_lut_engine: the Avalon-MM slave used to load the
// palettes and control registers, and the streaming pixel lookup path.
//   master : drives avs_* requests and pix_* lookups, receives readdata/out_*
//   slave  : the engine side (receives requests, drives readdata and out_*)
// ---------------------------------------------------------------------------
interface palette_lut_engine_if #(
   parameter int NUM_PALETTES = 4,
   parameter int INDEX_W      = 8,
   parameter int CW           = 4
);
   localparam int PAL_W = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
   localparam int AW    = PAL_W + INDEX_W + 1;

   // Avalon-MM slave
   logic             avs_chipselect;
   logic             avs_write;
   logic             avs_read;
   logic [AW-1:0]    avs_address;
   logic [31:0]      avs_writedata;
   logic [31:0]      avs_readdata;

   // Pixel lookup stream
   logic             pix_valid;
   logic [PAL_W-1:0] pix_bank;
   logic [INDEX_W-1:0] pix_index;
   logic             out_valid;
   logic [CW-1:0]    out_red;
   logic [CW-1:0]    out_green;
   logic [CW-1:0]    out_blue;
   logic             out_transparent;
   logic             fade_busy;

   modport master (
      output avs_chipselect, avs_write, avs_read, avs_address, avs_writedata,
      output pix_valid, pix_bank, pix_index,
      input  avs_readdata, out_valid, out_red, out_green, out_blue,
      input  out_transparent, fade_busy
   );

   modport slave (
      input  avs_chipselect, avs_write, avs_read, avs_address, avs_writedata,
      input  pix_valid, pix_bank, pix_index,
      output avs_readdata, out_valid, out_red, out_green, out_blue,
      output out_transparent, fade_busy
   );
endinterface

// File: rtl/palette_lut_engine.sv
// ---------------------------------------------------------------------------
// palette_lut_engine
// CPU-writable multi-bank colour palette. Converts (bank, index) pixel
// requests into registered RGB with a fixed 2-cycle latency, applies
// transparency keying and a stepped brightness fade.
//   Clk   : system clock
//   Reset : asynchronous, active-high reset
//   bus   : palette_lut_engine_if.slave
//           avs_*  - palette entries (address MSB=0) and control regs (MSB=1)
//                    reg0 KEY [INDEX_W-1:0]=key, [16]=key_en  (R/W)
//                    reg1 FADE_TARGET [3:0]                  (R/W)
//                    reg2 STATUS [3:0]=level, [8]=fade_busy  (RO)
//                    reg3 reads 0
//           pix_*  - lookup request; out_* - faded colour, 2 cycles later
// ---------------------------------------------------------------------------
module palette_lut_engine #(
   parameter int NUM_PALETTES = 4,
   parameter int INDEX_W      = 8,
   parameter int CW           = 4,
   parameter int FADE_DIV     = 65536
) (
   input logic                  Clk,
   input logic                  Reset,
   palette_lut_engine_if.slave  bus
);
   localparam int PAL_W  = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
   localparam int AW     = PAL_W + INDEX_W + 1;
   localparam int RAM_AW = PAL_W + INDEX_W;
   localparam int DEPTH  = NUM_PALETTES * (2 ** INDEX_W);
   localparam int EW     = 3 * CW;
   localparam int CNT_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

   typedef enum logic {S_IDLE, S_FADING} fade_state_t;

   // ---------------- Avalon decode ----------------
   logic               w_ctrl_sel;
   logic [1:0]         w_reg_sel;
   logic [PAL_W-1:0]   w_wr_bank;
   logic [INDEX_W-1:0] w_wr_index;
   logic               w_ram_we;
   logic               w_reg_we;
   logic [31:0]        w_rd_data;

   assign w_ctrl_sel = bus.avs_address[AW-1];
   assign w_reg_sel  = bus.avs_address[1:0];
   assign w_wr_bank  = bus.avs_address[INDEX_W +: PAL_W];
   assign w_wr_index = bus.avs_address[INDEX_W-1:0];
   assign w_ram_we   = bus.avs_chipselect & bus.avs_write & ~w_ctrl_sel &
                       (32'(w_wr_bank) < NUM_PALETTES);
   assign w_reg_we   = bus.avs_chipselect & bus.avs_write & w_ctrl_sel;

   // ---------------- Control / status registers ----------------
   logic [INDEX_W-1:0] r_key;
   logic               r_key_en;
   logic [3:0]         r_target;
   logic [3:0]         r_level;
   logic [CNT_W-1:0]   r_cnt;
   fade_state_t        r_state;
   logic [31:0]        r_readdata;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_rd_data = '0;
      if (w_ctrl_sel) begin
         case (w_reg_sel)
            2'd0: begin
               w_rd_data[INDEX_W-1:0] = r_key;
               w_rd_data[16]          = r_key_en;
            end
            2'd1: w_rd_data[3:0] = r_target;
            2'd2: begin
               w_rd_data[3:0] = r_level;
               w_rd_data[8]   = (r_state == S_FADING);
            end
            default: w_rd_data = '0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_key      <= '0;
         r_key_en   <= 1'b0;
         r_target   <= 4'd15;
         r_readdata <= '0;
      end else begin
         if (w_reg_we) begin
            case (w_reg_sel)
               2'd0: begin
                  r_key    <= bus.avs_writedata[INDEX_W-1:0];
                  r_key_en <= bus.avs_writedata[16];
               end
               2'd1: r_target <= bus.avs_writedata[3:0];
               default: ;
            endcase
         end
         // Palette reads return 0 through the same decode; hold otherwise.
         if (bus.avs_chipselect & bus.avs_read)
            r_readdata <= w_rd_data;
      end
   end

   // ---------------- Fade FSM ----------------
   // The counter keeps running across retargets, so a reversal keeps the
   // existing step cadence.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_level <= 4'd15;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (r_target != r_level)
                  r_state <= S_FADING;
            end
            S_FADING: begin
               if (r_target == r_level) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_W'(FADE_DIV - 1)) begin
                  r_cnt <= '0;
                  if (r_target > r_level) begin
                     r_level <= r_level + 4'd1;
                     if (r_target == r_level + 4'd1) r_state <= S_IDLE;
                  end else begin
                     r_level <= r_level - 4'd1;
                     if (r_target == r_level - 4'd1) r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ---------------- Palette RAM ----------------
   logic [EW-1:0] r_ram [0:DEPTH-1];
   logic [EW-1:0] r_ram_q;

   // NOTE: the RAM array has no reset so it maps onto block RAM; only the
   // pipeline control registers around it are reset.
   // Write and read share one edge; the read samples the pre-write contents,
   // giving read-before-write on a same-entry collision.
   always_ff @(posedge Clk) begin
      if (w_ram_we)
         r_ram[RAM_AW'({w_wr_bank, w_wr_index})] <= bus.avs_writedata[EW-1:0];
      if (bus.pix_valid && (32'(bus.pix_bank) < NUM_PALETTES))
         r_ram_q <= r_ram[RAM_AW'({bus.pix_bank, bus.pix_index})];
   end

   // ---------------- Pixel pipeline ----------------
   logic r_s1_valid;
   logic r_s1_bank_ok;
   logic r_s1_key;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_s1_valid   <= 1'b0;
         r_s1_bank_ok <= 1'b0;
         r_s1_key     <= 1'b0;
      end else begin
         r_s1_valid   <= bus.pix_valid;
         r_s1_bank_ok <= (32'(bus.pix_bank) < NUM_PALETTES);
         r_s1_key     <= r_key_en & (bus.pix_index == r_key);
      end
   end

   // (c * (L+1)) >> 4 with a CW+5-bit product; L=15 is identity.
   function automatic logic [CW-1:0] f_fade(input logic [CW-1:0] c,
                                            input logic [3:0] l);
      logic [CW+4:0] prod;
      prod = {5'd0, c} * {{CW{1'b0}}, {1'b0, l} + 5'd1};
      if (l == 4'd0) return '0;
      return prod[CW+3:4];
   endfunction

   logic          r_out_valid;
   logic [CW-1:0] r_out_red, r_out_green, r_out_blue;
   logic          r_out_transparent;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_out_valid       <= 1'b0;
         r_out_red         <= '0;
         r_out_green       <= '0;
         r_out_blue        <= '0;
         r_out_transparent <= 1'b0;
      end else begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_transparent <= r_s1_key;
            if (r_s1_key || !r_s1_bank_ok) begin
               r_out_red   <= '0;
               r_out_green <= '0;
               r_out_blue  <= '0;
            end else begin
               r_out_red   <= f_fade(r_ram_q[EW-1 -: CW], r_level);
               r_out_green <= f_fade(r_ram_q[2*CW-1 -: CW], r_level);
               r_out_blue  <= f_fade(r_ram_q[CW-1:0], r_level);
            end
         end
      end
   end

   assign bus.avs_readdata    = r_readdata;
   assign bus.out_valid       = r_out_valid;
   assign bus.out_red         = r_out_red;
   assign bus.out_green       = r_out_green;
   assign bus.out_blue        = r_out_blue;
   assign bus.out_transparent = r_out_transparent;
   assign bus.fade_busy       = (r_state == S_FADING);
endmodule

// File: tb/tb_palette_lut_engine.sv
// ---------------------------------------------------------------------------
// tb_palette_lut_engine
// Directed stimulus with hand-computed expectations. Pixel and register-read
// expectations are queued when issued; monitors pop them when the DUT
// presents out_valid or the cycle after a read strobe.
// ---------------------------------------------------------------------------
module tb_palette_lut_engine;
   localparam int NP  = 3;
   localparam int IW  = 8;
   localparam int CW  = 4;
   localparam int FD  = 4;
   localparam logic [10:0] A_KEY    = 11'h400;
   localparam logic [10:0] A_TARGET = 11'h401;
   localparam logic [10:0] A_STATUS = 11'h402;

   typedef struct {
      logic [12:0] pix;   // {transparent, R, G, B}
      int          cyc;
   } pix_exp_t;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   palette_lut_engine_if #(.NUM_PALETTES(NP), .INDEX_W(IW), .CW(CW)) bus ();

   palette_lut_engine #(.NUM_PALETTES(NP), .INDEX_W(IW), .CW(CW),
                        .FADE_DIV(FD)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc = cyc + 1;

   pix_exp_t    pix_q[$];
   logic [31:0] rd_q[$];
   logic        rd_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- Monitors ----------------
   always @(posedge Clk) rd_seen <= bus.avs_chipselect & bus.avs_read;

   always @(negedge Clk) begin
      if (bus.out_valid) begin
         if (pix_q.size() == 0) begin
            check("unexpected_pixel", 32'(bus.out_valid), 32'd0);
         end else begin
            pix_exp_t e;
            e = pix_q.pop_front();
            check("pixel", {19'd0, bus.out_transparent, bus.out_red,
                            bus.out_green, bus.out_blue}, {19'd0, e.pix});
            check("pixel_latency", 32'(cyc - e.cyc), 32'd2);
         end
      end
      if (rd_seen) begin
         if (rd_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
         else check("readdata", bus.avs_readdata, rd_q.pop_front());
      end
   end

   // ---------------- Stimulus tasks (called at a negedge) ----------------
   task automatic idle_bus();
      bus.avs_chipselect = 1'b0;
      bus.avs_write      = 1'b0;
      bus.avs_read       = 1'b0;
      bus.pix_valid      = 1'b0;
   endtask

   task automatic av_write(input logic [10:0] addr, input logic [31:0] data);
      bus.avs_chipselect = 1'b1;
      bus.avs_write      = 1'b1;
      bus.avs_address    = addr;
      bus.avs_writedata  = data;
      @(negedge Clk);
      bus.avs_chipselect = 1'b0;
      bus.avs_write      = 1'b0;
   endtask

   task automatic av_read(input logic [10:0] addr, input logic [31:0] exp);
      bus.avs_chipselect = 1'b1;
      bus.avs_read       = 1'b1;
      bus.avs_address    = addr;
      rd_q.push_back(exp);
      @(negedge Clk);
      bus.avs_chipselect = 1'b0;
      bus.avs_read       = 1'b0;
   endtask

   task automatic pix_drive(input logic [1:0] bank, input logic [7:0] idx,
                            input logic [12:0] exp);
      pix_exp_t e;
      bus.pix_valid = 1'b1;
      bus.pix_bank  = bank;
      bus.pix_index = idx;
      e.pix = exp;
      e.cyc = cyc;
      pix_q.push_back(e);
   endtask

   task automatic pix(input logic [1:0] bank, input logic [7:0] idx,
                      input logic [12:0] exp);
      pix_drive(bank, idx, exp);
      @(negedge Clk);
      bus.pix_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(negedge Clk);
   endtask

   function automatic logic [10:0] pa(input logic [1:0] bank,
                                      input logic [7:0] idx);
      return {1'b0, bank, idx};
   endfunction

   // ---------------- Test sequence ----------------
   initial begin : main
      int busy_cnt;
      int guard;
      idle_bus();
      bus.avs_address   = '0;
      bus.avs_writedata = '0;
      bus.pix_bank      = '0;
      bus.pix_index     = '0;
      repeat (3) @(negedge Clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_rgb", {20'd0, bus.out_red, bus.out_green, bus.out_blue}, 32'd0);
      check("rst_readdata", bus.avs_readdata, 32'd0);
      Reset = 1'b0;
      @(negedge Clk);
      check("rst_busy", 32'(bus.fade_busy), 32'd0);
      av_read(A_STATUS, 32'h0000_000F);
      av_read(A_KEY, 32'h0);
      av_read(A_TARGET, 32'hF);

      // Basic lookups, back-to-back streaming, level 15 is identity.
      av_write(pa(2'd1, 8'h23), 32'h0000_0ABC);
      av_write(pa(2'd1, 8'h24), 32'h0000_0123);
      av_read(pa(2'd1, 8'h23), 32'h0);
      pix(2'd1, 8'h23, 13'h0ABC);
      pix(2'd1, 8'h24, 13'h0123);
      drain();

      // Read-before-write collision.
      av_write(pa(2'd0, 8'h07), 32'h111);
      bus.avs_chipselect = 1'b1;
      bus.avs_write      = 1'b1;
      bus.avs_address    = pa(2'd0, 8'h07);
      bus.avs_writedata  = 32'h555;
      pix_drive(2'd0, 8'h07, 13'h0111);
      @(negedge Clk);
      bus.avs_chipselect = 1'b0;
      bus.avs_write      = 1'b0;
      pix(2'd0, 8'h07, 13'h0555);
      drain();

      // Transparency key.
      av_write(pa(2'd0, 8'h08), 32'h9A5);
      av_write(A_KEY, 32'h0001_0007);
      av_read(A_KEY, 32'h0001_0007);
      pix(2'd0, 8'h07, 13'h1000);
      pix(2'd0, 8'h08, 13'h09A5);
      drain();
      av_write(A_KEY, 32'h0);
      pix(2'd0, 8'h07, 13'h0555);
      drain();

      // Out-of-range bank: write ignored, lookup black; bank 2 unaffected.
      av_write(pa(2'd2, 8'h05), 32'h777);
      av_write(pa(2'd3, 8'h05), 32'hFFF);
      pix(2'd3, 8'h05, 13'h0000);
      pix(2'd2, 8'h05, 13'h0777);
      drain();

      // Fade 15 -> 7: 8 steps of FADE_DIV cycles.
      av_write(pa(2'd0, 8'h09), 32'hF80);
      av_write(A_TARGET, 32'h7);
      busy_cnt = 0;
      guard    = 0;
      do begin
         @(negedge Clk);
         guard++;
         if (bus.fade_busy) busy_cnt++;
      end while ((bus.fade_busy || guard == 1) && guard < 200);
      check("fade_busy_cycles", 32'(busy_cnt), 32'd32);
      check("fade_done_busy", 32'(bus.fade_busy), 32'd0);
      av_read(A_STATUS, 32'h0000_0007);
      pix(2'd0, 8'h09, 13'h0740);
      pix(2'd1, 8'h23, 13'h0556);
      drain();

      // Retarget mid-fade: heading to 0, reverse to 15.
      av_write(A_TARGET, 32'h0);
      repeat (9) @(negedge Clk);
      av_write(A_TARGET, 32'hF);
      av_read(A_STATUS, 32'h0000_0105);
      repeat (4) @(negedge Clk);
      av_read(A_STATUS, 32'h0000_0106);
      @(negedge Clk);
      @(negedge Clk);

      // Asynchronous reset mid-fade, with a lookup in flight.
      bus.pix_valid = 1'b1;
      bus.pix_bank  = 2'd1;
      bus.pix_index = 8'h23;
      @(negedge Clk);
      bus.pix_valid = 1'b0;
      #2 Reset = 1'b1;
      #1;
      check("async_rst_busy", 32'(bus.fade_busy), 32'd0);
      check("async_rst_valid", 32'(bus.out_valid), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      av_read(A_STATUS, 32'h0000_000F);
      av_read(A_KEY, 32'h0);
      pix(2'd1, 8'h23, 13'h0ABC);
      drain();

      check("pix_queue_empty", 32'(pix_q.size()), 32'd0);
      check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
